// File: rtl/ace_controller.sv
// ============================================================================
// ace_controller : one-line-per-request ACE master (fill / writeback / CleanUnique)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module ace_controller #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   // cache controller side
   input  logic                    read_req,
   input  logic                    write_req,
   input  logic                    invalid_req,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [4*DATA_WIDTH-1:0] wb_line,
   output logic [4*DATA_WIDTH-1:0] rd_line,
   output logic                    ace_ready,
   output logic                    ace_error,
   // read address / snoop channel
   output logic                    arvalid,
   input  logic                    arready,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [3:0]              arsnoop,
   // read data channel
   input  logic                    rvalid,
   output logic                    rready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [3:0]              rresp,
   output logic                    rack,
   // write address channel
   output logic                    awvalid,
   input  logic                    awready,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   // write data channel
   output logic                    wvalid,
   input  logic                    wready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic                    wlast,
   // write response channel
   input  logic                    bvalid,
   output logic                    bready,
   input  logic [1:0]              bresp
);

   localparam logic [3:0] C_SNOOP_READ_SHARED = 4'b0001;
   localparam logic [3:0] C_SNOOP_CLEAN_UNIQ  = 4'b1011;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_RD_ADDR  = 4'd1,
      S_RD_DATA  = 4'd2,
      S_INV_ADDR = 4'd3,
      S_INV_RESP = 4'd4,
      S_WR_ADDR  = 4'd5,
      S_WR_DATA  = 4'd6,
      S_WR_RESP  = 4'd7,
      S_DONE     = 4'd8
   } state_t;

   state_t                  state_q, state_d;
   logic [1:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [4*DATA_WIDTH-1:0] wb_q, wb_d;
   logic [4*DATA_WIDTH-1:0] rd_q, rd_d;
   logic                    err_q, err_d;
   logic                    wr_q, wr_d;

   // Only the low two rresp bits carry the error status.
   logic                    unused_rresp_hi;
   assign unused_rresp_hi = ^rresp[3:2];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         addr_q  <= '0;
         wb_q    <= '0;
         rd_q    <= '0;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wb_q    <= wb_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
         wr_q    <= wr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wb_d      = wb_q;
      rd_d      = rd_q;
      err_d     = err_q;
      wr_d      = wr_q;
      arvalid   = 1'b0;
      arsnoop   = 4'b0000;
      rready    = 1'b0;
      rack      = 1'b0;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      wdata     = '0;
      wlast     = 1'b0;
      bready    = 1'b0;
      ace_ready = 1'b0;
      ace_error = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Writeback wins so a dirty victim leaves before its replacement fill.
            if (write_req || read_req || invalid_req) begin
               addr_d = req_addr;
               wb_d   = wb_line;
               err_d  = 1'b0;
               wr_d   = write_req;
               if (write_req)     state_d = S_WR_ADDR;
               else if (read_req) state_d = S_RD_ADDR;
               else               state_d = S_INV_ADDR;
            end
         end
         S_RD_ADDR: begin
            arvalid = 1'b1;
            arsnoop = C_SNOOP_READ_SHARED;
            if (arready) begin
               cnt_d   = 2'd0;
               state_d = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            rready = 1'b1;
            if (rvalid) begin
               rd_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = rdata;
               if (|rresp[1:0]) err_d = 1'b1;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = S_DONE;
            end
         end
         S_INV_ADDR: begin
            arvalid = 1'b1;
            arsnoop = C_SNOOP_CLEAN_UNIQ;
            if (arready) state_d = S_INV_RESP;
         end
         S_INV_RESP: begin
            rready = 1'b1;
            if (rvalid) begin
               if (|rresp[1:0]) err_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_WR_ADDR: begin
            awvalid = 1'b1;
            if (awready) begin
               cnt_d   = 2'd0;
               state_d = S_WR_DATA;
            end
         end
         S_WR_DATA: begin
            wvalid = 1'b1;
            wdata  = wb_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
            wlast  = (cnt_q == 2'd3);
            if (wready) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            bready = 1'b1;
            if (bvalid) begin
               if (|bresp) err_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            ace_ready = 1'b1;
            ace_error = err_q;
            rack      = ~wr_q;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign rd_line = rd_q;
   assign araddr  = addr_q;
   assign awaddr  = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_ace_controller.sv
// ============================================================================
// tb_ace_controller : directed self-checking bench for ace_controller
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_ace_controller;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    read_req, write_req, invalid_req;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [4*DATA_WIDTH-1:0] wb_line;
   logic [4*DATA_WIDTH-1:0] rd_line;
   logic                    ace_ready, ace_error;
   logic                    arvalid, arready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [3:0]              arsnoop;
   logic                    rvalid, rready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [3:0]              rresp;
   logic                    rack;
   logic                    awvalid, awready;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    wvalid, wready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic                    wlast;
   logic                    bvalid, bready;
   logic [1:0]              bresp;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   ace_controller #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
      .clk(clk), .reset(reset),
      .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
      .req_addr(req_addr), .wb_line(wb_line), .rd_line(rd_line),
      .ace_ready(ace_ready), .ace_error(ace_error),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsnoop(arsnoop),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rack(rack),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_arvalid"}, arvalid, 1'b0);
      check_eq({tag, "_rready"},  rready,  1'b0);
      check_eq({tag, "_awvalid"}, awvalid, 1'b0);
      check_eq({tag, "_wvalid"},  wvalid,  1'b0);
      check_eq({tag, "_bready"},  bready,  1'b0);
      check_eq({tag, "_ready"},   ace_ready, 1'b0);
      check_eq({tag, "_rack"},    rack,    1'b0);
   endtask

   // Zero-wait line fill with four data beats, checked from request to IDLE.
   task automatic run_read(input string tag, input logic [31:0] a,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
      read_req = 1'b1; req_addr = a;
      tick();
      read_req = 1'b0;
      check_eq({tag, "_arvalid"}, arvalid, 1'b1);
      check_eq({tag, "_arsnoop"}, arsnoop, 4'b0001);
      check_eq({tag, "_araddr"},  araddr,  a);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      check_eq({tag, "_rready"},  rready,  1'b1);
      check_eq({tag, "_ar_drop"}, arvalid, 1'b0);
      rvalid = 1'b1;
      rdata = d0; tick();
      rdata = d1; tick();
      rdata = d2; tick();
      rdata = d3; tick();
      rvalid = 1'b0;
      check_eq({tag, "_ready"}, ace_ready, 1'b1);
      check_eq({tag, "_rack"},  rack,      1'b1);
      check_eq({tag, "_err"},   ace_error, 1'b0);
      check_eq({tag, "_line"},  rd_line,   {d3, d2, d1, d0});
      tick();
      check_eq({tag, "_ready_off"}, ace_ready, 1'b0);
      check_eq({tag, "_rack_off"},  rack,      1'b0);
   endtask

   initial begin
      reset = 1'b1;
      read_req = 0; write_req = 0; invalid_req = 0;
      req_addr = '0; wb_line = '0;
      arready = 0; rvalid = 0; rdata = '0; rresp = '0;
      awready = 0; wready = 0; bvalid = 0; bresp = '0;
      tick(); tick();
      check_quiet("rst");
      check_eq("rst_line", rd_line, 128'd0);
      reset = 1'b0;
      tick();

      // Basic fill.
      run_read("rd1", 32'h0000_1000, 32'hA, 32'hB, 32'hC, 32'hD);

      // Writeback with a two-cycle wready stall on beat 1.
      write_req = 1'b1; req_addr = 32'h0000_2000;
      wb_line = {32'd4, 32'd3, 32'd2, 32'd1};
      tick();
      write_req = 1'b0;
      check_eq("wr_awvalid", awvalid, 1'b1);
      check_eq("wr_awaddr",  awaddr,  32'h0000_2000);
      check_eq("wr_arvalid", arvalid, 1'b0);
      awready = 1'b1;
      tick();
      awready = 1'b0;
      check_eq("wr_wvalid0", wvalid, 1'b1);
      check_eq("wr_wdata0",  wdata,  32'd1);
      check_eq("wr_wlast0",  wlast,  1'b0);
      check_eq("wr_aw_drop", awvalid, 1'b0);
      wready = 1'b1;
      tick();
      check_eq("wr_wdata1", wdata, 32'd2);
      wready = 1'b0;
      tick();
      check_eq("wr_stall1", wdata, 32'd2);
      check_eq("wr_stall1_last", wlast, 1'b0);
      tick();
      check_eq("wr_stall2", wdata, 32'd2);
      wready = 1'b1;
      tick();
      check_eq("wr_wdata2", wdata, 32'd3);
      check_eq("wr_wlast2", wlast, 1'b0);
      tick();
      check_eq("wr_wdata3", wdata, 32'd4);
      check_eq("wr_wlast3", wlast, 1'b1);
      tick();
      wready = 1'b0;
      check_eq("wr_bready",  bready, 1'b1);
      check_eq("wr_w_drop",  wvalid, 1'b0);
      check_eq("wr_wlast_off", wlast, 1'b0);
      tick();
      check_eq("wr_wait_b", ace_ready, 1'b0);
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      check_eq("wr_ready", ace_ready, 1'b1);
      check_eq("wr_rack",  rack,      1'b0);
      check_eq("wr_err",   ace_error, 1'b0);
      tick();
      check_eq("wr_ready_off", ace_ready, 1'b0);

      // Simultaneous write and read: write first, read starts after DONE.
      write_req = 1'b1; read_req = 1'b1; req_addr = 32'h0000_3000;
      wb_line = {32'h44, 32'h33, 32'h22, 32'h11};
      tick();
      write_req = 1'b0;
      check_eq("pri_awvalid", awvalid, 1'b1);
      check_eq("pri_arvalid", arvalid, 1'b0);
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
      repeat (6) tick();
      check_eq("pri_wr_ready", ace_ready, 1'b1);
      check_eq("pri_wr_rack",  rack,      1'b0);
      check_eq("pri_done_ar",  arvalid,   1'b0);
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      req_addr = 32'h0000_3040;
      tick();
      check_eq("pri_idle_ar",    arvalid,   1'b0);
      check_eq("pri_idle_ready", ace_ready, 1'b0);
      tick();
      read_req = 1'b0;
      check_eq("pri_rd_ar",     arvalid, 1'b1);
      check_eq("pri_rd_snoop",  arsnoop, 4'b0001);
      check_eq("pri_rd_addr",   araddr,  32'h0000_3040);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      rvalid = 1'b1;
      rdata = 32'h5; tick();
      rdata = 32'h6; tick();
      rdata = 32'h7; tick();
      rdata = 32'h8; tick();
      rvalid = 1'b0;
      check_eq("pri_rd_ready", ace_ready, 1'b1);
      check_eq("pri_rd_rack",  rack,      1'b1);
      check_eq("pri_rd_line",  rd_line, {32'h8, 32'h7, 32'h6, 32'h5});
      tick();

      // CleanUnique with an error response, minimum latency.
      invalid_req = 1'b1; req_addr = 32'h0000_4040;
      tick();
      invalid_req = 1'b0;
      check_eq("inv_arvalid", arvalid, 1'b1);
      check_eq("inv_arsnoop", arsnoop, 4'b1011);
      check_eq("inv_araddr",  araddr,  32'h0000_4040);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      check_eq("inv_rready", rready, 1'b1);
      rvalid = 1'b1; rresp = 4'b0010;
      tick();
      rvalid = 1'b0; rresp = 4'b0000;
      check_eq("inv_ready", ace_ready, 1'b1);
      check_eq("inv_err",   ace_error, 1'b1);
      check_eq("inv_rack",  rack,      1'b1);
      check_eq("inv_rready_off", rready, 1'b0);
      tick();
      check_eq("inv_err_off", ace_error, 1'b0);

      // Reset in the middle of a fill, then a clean fill.
      read_req = 1'b1; req_addr = 32'h0000_5000;
      tick();
      read_req = 1'b0;
      arready = 1'b1;
      tick();
      arready = 1'b0;
      rvalid = 1'b1;
      rdata = 32'h1; tick();
      rdata = 32'h2; tick();
      rvalid = 1'b0;
      reset = 1'b1;
      tick();
      check_quiet("mid_rst");
      check_eq("mid_rst_line", rd_line, 128'd0);
      reset = 1'b0;
      tick();
      check_quiet("post_rst");
      run_read("rd2", 32'h0000_6000, 32'hE, 32'hF, 32'h10, 32'h11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire
